// File: rtl/i2c_master_ctrl_if.sv
// Command and bus signals of the I2C master, grouped for the master/slave sides.
//
// Command handshake: a one-cycle start is accepted only while busy=0 (the
// address, rorw and write_data fields are latched on that edge); busy rises the
// following cycle and stays high until the single-cycle done pulse, during
// which busy is already low. A start while busy=1 is dropped, not queued.
interface i2c_master_ctrl_if #(
  parameter int ADDRESSLENGTH = 7,
  parameter int NBYTES        = 1
);
  logic                       start;
  logic [ADDRESSLENGTH-1:0]   address;
  logic                       rorw;
  logic [8*NBYTES-1:0]        write_data;
  logic [8*NBYTES-1:0]        read_data;
  logic                       busy;
  logic                       done;
  logic                       ack_err;
  logic                       scl;
  logic                       sda_oe;
  logic                       sda_in;
  logic                       scl_in;
  logic [3:0]                 dbg_state;

  modport master (
    input  start, address, rorw, write_data, sda_in, scl_in,
    output read_data, busy, done, ack_err, scl, sda_oe, dbg_state
  );

  modport slave (
    output start, address, rorw, write_data, sda_in, scl_in,
    input  read_data, busy, done, ack_err, scl, sda_oe, dbg_state
  );
endinterface

// File: rtl/i2c_master_ctrl.sv
// I2C master: one START / address+R/W / NBYTES data / STOP transaction per
// accepted start. Each bit is four quarters of CLKDIV clocks: SCL low in Q0-Q1
// (SDA changes at Q0), high in Q2-Q3 (SDA sampled on the last clock of Q2).
// Optional feature: define I2C_MASTER_CLKSTRETCH_EN to let a slave stretch SCL
// (the quarter counter holds in Q2 while scl_in is low).
module i2c_master_ctrl #(
  parameter int ADDRESSLENGTH = 7,
  parameter int NBYTES        = 1,
  parameter int CLKDIV        = 4
) (
  input logic             clk,
  input logic             rst,
  i2c_master_ctrl_if.master bus
);

  localparam int CW = $clog2(CLKDIV);
  localparam int IW = ($clog2(ADDRESSLENGTH + 1) > 3) ? $clog2(ADDRESSLENGTH + 1) : 3;
  localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_STOP, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt;
  logic [1:0]             q;
  logic [IW-1:0]          bit_idx;
  logic [BW-1:0]          byte_idx;
  logic [ADDRESSLENGTH:0] addr_sh;     // {address, rorw}, MSB is the bit on the wire
  logic                   rorw_q;
  logic [8*NBYTES-1:0]    wdata_q;     // remaining write bytes, next byte in [7:0]
  logic [8*NBYTES-1:0]    rdata_q;
  logic [7:0]             byte_sh;     // byte being sent or received
  logic                   samp;        // SDA level sampled at the end of Q2
  logic                   ack_err_q, busy_q, done_q;
  logic                   active, hold, tick, q_end, bit_end, samp_pt, last_byte;
  logic                   scl_c, sda_oe_c;

  assign active = (state_q != S_IDLE) && (state_q != S_DONE);

`ifdef I2C_MASTER_CLKSTRETCH_EN
  assign hold = (q == 2'd2) && !bus.scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = bus.scl_in;
  assign hold = 1'b0;
`endif

  assign tick      = active && !hold;
  assign q_end     = tick && (cnt == CW'(CLKDIV - 1));
  assign bit_end   = q_end && (q == 2'd3);
  assign samp_pt   = q_end && (q == 2'd2);
  assign last_byte = (byte_idx == BW'(NBYTES - 1));

  // State register; reset returns to IDLE, which releases SCL and SDA at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and bus levels decoded from state and quarter.
  always_comb begin
    state_d  = state_q;
    scl_c    = 1'b1;
    sda_oe_c = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_START;
      S_START: begin
        scl_c    = (q != 2'd3);
        sda_oe_c = q[1];
        if (bit_end) state_d = S_ADDR;
      end
      S_ADDR: begin
        scl_c    = q[1];
        sda_oe_c = ~addr_sh[ADDRESSLENGTH];
        if (bit_end && bit_idx == IW'(ADDRESSLENGTH)) state_d = S_AACK;
      end
      S_AACK: begin
        scl_c = q[1];
        if (bit_end) state_d = samp ? S_STOP : (rorw_q ? S_RDATA : S_WDATA);
      end
      S_WDATA: begin
        scl_c    = q[1];
        sda_oe_c = ~byte_sh[7];
        if (bit_end && bit_idx == IW'(7)) state_d = S_WACK;
      end
      S_WACK: begin
        scl_c = q[1];
        if (bit_end) state_d = (samp || last_byte) ? S_STOP : S_WDATA;
      end
      S_RDATA: begin
        scl_c = q[1];
        if (bit_end && bit_idx == IW'(7)) state_d = S_RACK;
      end
      S_RACK: begin
        scl_c    = q[1];
        sda_oe_c = !last_byte;   // ACK all but the final byte
        if (bit_end) state_d = last_byte ? S_STOP : S_RDATA;
      end
      S_STOP: begin
        scl_c    = q[1];
        sda_oe_c = (q != 2'd3);
        if (bit_end) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Quarter timing, command latch, shift registers and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      q         <= 2'd0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      addr_sh   <= '0;
      rorw_q    <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      byte_sh   <= '0;
      samp      <= 1'b0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tick) begin
        cnt <= q_end ? '0 : cnt + CW'(1);
        if (q_end) q <= q + 2'd1;
      end
      if (state_q == S_IDLE && bus.start) begin
        addr_sh   <= {bus.address, bus.rorw};
        rorw_q    <= bus.rorw;
        wdata_q   <= bus.write_data;
        ack_err_q <= 1'b0;
        busy_q    <= 1'b1;
        byte_idx  <= '0;
        bit_idx   <= '0;
      end
      if (state_q == S_DONE) begin
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
      if (samp_pt) begin
        samp <= bus.sda_in;
        if (state_q == S_RDATA) byte_sh <= {byte_sh[6:0], bus.sda_in};
      end
      if (bit_end) begin
        bit_idx <= (state_d == state_q) ? bit_idx + IW'(1) : '0;
        if (state_q == S_ADDR)  addr_sh <= {addr_sh[ADDRESSLENGTH-1:0], 1'b0};
        if (state_q == S_WDATA) byte_sh <= {byte_sh[6:0], 1'b0};
        if (state_d == S_WDATA && state_q != S_WDATA) begin
          byte_sh <= wdata_q[7:0];
          wdata_q <= wdata_q >> 8;
        end
        if ((state_q == S_WACK && state_d == S_WDATA) ||
            (state_q == S_RACK && state_d == S_RDATA))
          byte_idx <= byte_idx + BW'(1);
        if ((state_q == S_AACK || state_q == S_WACK) && samp) ack_err_q <= 1'b1;
        if (state_q == S_RDATA && state_d == S_RACK) begin
          for (int i = 0; i < NBYTES; i++)
            if (byte_idx == BW'(i)) rdata_q[i*8 +: 8] <= byte_sh;
        end
      end
    end
  end

  assign bus.scl       = scl_c;
  assign bus.sda_oe    = sda_oe_c;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ack_err   = ack_err_q;
  assign bus.read_data = rdata_q;
  assign bus.dbg_state = state_q;

endmodule
